wb_trace_fifo: RTL and testbench
================================

# wb_trace_fifo

Capture-side companion to the processor top level: it reads the register write-back stream that `Top` produces, filters writes to `$zero`, and buffers each event (destination register and value) in a first-word-fall-through FIFO. A downstream reader (display driver, bench checker or UART formatter) drains the buffer with a valid/ready handshake. Lost events are counted, and an overflow flag is set, so nothing disappears silently.

## Interface
Parameters:
- `DEPTH`, 16: number of FIFO entries; must be a power of two, minimum 2.
- `ADDR_W`, 4: log2(`DEPTH`); sizes the read and write pointers.

Ports:
- `clk`  in  1  single clock; every state element updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `wb_en`  in  1  write-back enable from the processor's WB stage.
- `wb_reg`  in  5  destination register number of the write-back.
- `wb_data`  in  32  value being written back.
- `rd_ready`  in  1  reader accepts the head entry this cycle.
- `rd_valid`  out  1  head entry is present.
- `rd_reg`  out  5  head entry register number.
- `rd_data`  out  32  head entry value.
- `count`  out  ADDR_W+1  number of stored entries, 0 to `DEPTH`.
- `overflow`  out  1  sticky flag; set when any event has been dropped.
- `drop_count`  out  16  number of dropped events; saturates at 0xFFFF.

## Operation
- Push request: `wb_en && (wb_reg != 0)`. A write to `$zero` is never stored and never counted as a drop.
- Pop: `rd_valid && rd_ready`. When `rd_valid` is 0, `rd_ready` is ignored.
- Storage is an array of `DEPTH` x 37 bits. The write pointer and read pointer are `ADDR_W` bits wide and wrap modulo `DEPTH`.
- Push only, not full: write the entry at the write pointer, advance the write pointer, `count` += 1.
- Push only, full: drop the entry; `drop_count` += 1 (saturating at 0xFFFF); `overflow` <= 1. Pointers and `count` do not change.
- Pop only: advance the read pointer, `count` -= 1.
- Push and pop in the same cycle, including when full: both take effect and `count` does not change. A full FIFO with a simultaneous pop accepts the push and records no drop.
- Push and pop when empty cannot occur, because `rd_valid` is 0.
- `rd_valid` = (`count` != 0).
- `rd_reg` and `rd_data` present the entry at the read pointer. They are forced to 0 when empty, so the outputs are deterministic.
- `overflow` is cleared only by `reset`.
- Entries leave in the order they were pushed; there is no reordering and no coalescing of writes to the same register.

## Timing
- Reset values: `rd_valid`=0, `rd_reg`=0, `rd_data`=0, `count`=0, `overflow`=0, `drop_count`=0, both pointers 0. Array contents are don't-care.
- Reset takes priority over every other input in the same cycle.
- Reset mid-operation discards all stored entries. Outputs show reset values in the cycle after the reset edge.
- Push latency is 1 cycle. An event sampled at edge N is visible on `rd_*`, with `rd_valid`=1, after edge N. There is no same-cycle bypass from `wb_*` to `rd_*`.
- Pop at edge N: the next entry, or empty, is shown after edge N.
- The reader may hold `rd_ready` high permanently. Sustained throughput is then 1 entry per cycle.
- `count`, `overflow` and `drop_count` are registered. They update on the same edge as the push, pop or drop that changes them.

## Test plan
- Reset then idle: `reset`=1 for 2 cycles, then no pushes. Required: `rd_valid`=0, `count`=0, `overflow`=0, `drop_count`=0, `rd_data`=0.
- Basic order: push (reg 8, 0x0000_0005), (reg 9, 0x0000_000A), (reg 0, 0xDEAD_BEEF) on consecutive cycles, with `rd_ready`=0. Required: `count`=2; head is reg 8 / 0x5. Then raise `rd_ready`. Required: reg 8 / 0x5, then reg 9 / 0xA, then `rd_valid`=0. `drop_count` stays 0.
- Fill and overflow: push 18 events, values 1..18, with `rd_ready`=0 and `DEPTH`=16. Required: `count`=16, `overflow`=1, `drop_count`=2. Draining yields exactly values 1..16.
- Full with simultaneous push and pop: fill 16 entries, then push value 0x99 while `rd_ready`=1. Required: `count` stays 16, `drop_count` unchanged, 0x99 emerges 16th after the pop.
- Pointer wrap: stream 40 pushes with `rd_ready`=1 every cycle. Required: all 40 values emerge in order, each 1 cycle after its push, and `count` never exceeds 1.
- Reset mid-operation: with 5 entries stored and `drop_count`=3, assert `reset` for 1 cycle. Required: all outputs return to reset values on the next cycle. The next push appears alone at the head.

Source files
------------

// File: rtl/wb_trace_fifo.sv
// wb_trace_fifo: captures register write-back events (destination register
// and value), drops writes to $zero, and buffers the events in a
// first-word-fall-through FIFO drained by a valid/ready reader. Events that
// arrive while the buffer is full are counted and flagged, never lost silently.
module wb_trace_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_en,
    input  logic [4:0]        wb_reg,
    input  logic [31:0]       wb_data,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [4:0]        rd_reg,
    output logic [31:0]       rd_data,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic [15:0]       drop_count
);

    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   ZERO_COUNT = {(ADDR_W + 1){1'b0}};
    localparam logic [ADDR_W:0]   ONE_COUNT  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ONE_PTR    = ADDR_W'(1);

    // Each entry is {register number, value}.
    logic [36:0]       mem_r [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [ADDR_W:0]   count_r;
    logic              overflow_r;
    logic [15:0]       drop_count_r;

    logic              push_s;
    logic              pop_s;
    logic              full_s;
    logic              accept_s;
    logic              drop_s;
    logic              valid_s;
    logic [36:0]       head_s;

    // Decode push/pop requests and decide whether a push is stored or dropped.
    always_comb begin
        push_s   = 1'b0;
        pop_s    = 1'b0;
        full_s   = 1'b0;
        accept_s = 1'b0;
        drop_s   = 1'b0;
        valid_s  = (count_r != ZERO_COUNT);
        full_s   = (count_r == FULL_COUNT);
        push_s   = wb_en && (wb_reg != 5'd0);
        pop_s    = valid_s && rd_ready;
        if (push_s) begin
            // A pop in the same cycle frees the slot, so a full FIFO still accepts.
            accept_s = !full_s || pop_s;
            drop_s   = full_s && !pop_s;
        end else begin
            accept_s = 1'b0;
            drop_s   = 1'b0;
        end
    end

    // Present the head entry, forced to zero when the FIFO is empty.
    always_comb begin
        head_s = mem_r[rd_ptr_r];
        if (valid_s) begin
            rd_reg  = head_s[36:32];
            rd_data = head_s[31:0];
        end else begin
            rd_reg  = 5'd0;
            rd_data = 32'd0;
        end
    end

    assign rd_valid   = valid_s;
    assign count      = count_r;
    assign overflow   = overflow_r;
    assign drop_count = drop_count_r;

    // Store an accepted event at the write pointer; contents need no reset.
    always_ff @(posedge clk) begin
        if (!reset && accept_s) begin
            mem_r[wr_ptr_r] <= {wb_reg, wb_data};
        end
    end

    // Pointer, occupancy and loss bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r     <= {ADDR_W{1'b0}};
            rd_ptr_r     <= {ADDR_W{1'b0}};
            count_r      <= ZERO_COUNT;
            overflow_r   <= 1'b0;
            drop_count_r <= 16'd0;
        end else begin
            if (accept_s) begin
                wr_ptr_r <= wr_ptr_r + ONE_PTR;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + ONE_PTR;
            end
            case ({accept_s, pop_s})
                2'b10:   count_r <= count_r + ONE_COUNT;
                2'b01:   count_r <= count_r - ONE_COUNT;
                default: count_r <= count_r;
            endcase
            if (drop_s) begin
                overflow_r <= 1'b1;
                if (drop_count_r != 16'hFFFF) begin
                    drop_count_r <= drop_count_r + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Directed bench for wb_trace_fifo. A queue-based model of the trace buffer
// is advanced every cycle and compared with all DUT outputs; literal
// expectations at key points pin the model itself.
module tb_wb_trace_fifo;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              wb_en = 1'b0;
    logic [4:0]        wb_reg = 5'd0;
    logic [31:0]       wb_data = 32'd0;
    logic              rd_ready = 1'b0;
    logic              rd_valid;
    logic [4:0]        rd_reg;
    logic [31:0]       rd_data;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic [15:0]       drop_count;

    int errors = 0;
    int checks = 0;

    // Model state
    logic [36:0] mq[$];
    int          m_drops = 0;
    bit          m_ovf = 1'b0;

    wb_trace_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .wb_en(wb_en), .wb_reg(wb_reg),
        .wb_data(wb_data), .rd_ready(rd_ready), .rd_valid(rd_valid),
        .rd_reg(rd_reg), .rd_data(rd_data), .count(count),
        .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit   do_pop;
        bit   do_push;
        bit   was_full;
        if (reset) begin
            mq.delete();
            m_drops = 0;
            m_ovf   = 1'b0;
        end else begin
            was_full = (mq.size() == DEPTH);
            do_pop   = (mq.size() != 0) && rd_ready;
            do_push  = wb_en && (wb_reg != 5'd0);
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                if (!was_full || do_pop) mq.push_back({wb_reg, wb_data});
                else begin
                    m_ovf = 1'b1;
                    if (m_drops < 65535) m_drops++;
                end
            end
        end
    endtask

    // Compare every DUT output with the model.
    task automatic compare();
        logic [36:0] head;
        head = (mq.size() != 0) ? mq[0] : 37'd0;
        check("rd_valid",   64'(rd_valid),   64'(mq.size() != 0));
        check("count",      64'(count),      64'(mq.size()));
        check("rd_reg",     64'(rd_reg),     64'(head[36:32]));
        check("rd_data",    64'(rd_data),    64'(head[31:0]));
        check("overflow",   64'(overflow),   64'(m_ovf));
        check("drop_count", 64'(drop_count), 64'(m_drops));
    endtask

    // Drive one cycle of inputs, clock it, update the model, then compare.
    task automatic cycle(input logic rst, input logic en, input logic [4:0] r,
                         input logic [31:0] d, input logic rdy);
        reset    = rst;
        wb_en    = en;
        wb_reg   = r;
        wb_data  = d;
        rd_ready = rdy;
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    initial begin
        // Reset then idle
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        check("idle_valid", 64'(rd_valid), 64'd0);
        check("idle_count", 64'(count), 64'd0);
        check("idle_data", 64'(rd_data), 64'd0);
        check("idle_ovf", 64'(overflow), 64'd0);
        check("idle_drops", 64'(drop_count), 64'd0);

        // Basic order, $zero filtered
        cycle(1'b0, 1'b1, 5'd8, 32'h0000_0005, 1'b0);
        check("push_latency_valid", 64'(rd_valid), 64'd1);
        cycle(1'b0, 1'b1, 5'd9, 32'h0000_000A, 1'b0);
        cycle(1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0);
        check("basic_count", 64'(count), 64'd2);
        check("basic_head_reg", 64'(rd_reg), 64'd8);
        check("basic_head_data", 64'(rd_data), 64'h5);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        check("basic_second_reg", 64'(rd_reg), 64'd9);
        check("basic_second_data", 64'(rd_data), 64'hA);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        check("basic_empty", 64'(rd_valid), 64'd0);
        check("basic_drops", 64'(drop_count), 64'd0);

        // Fill and overflow
        for (int i = 1; i <= 18; i++)
            cycle(1'b0, 1'b1, 5'((i % 31) + 1), 32'(i), 1'b0);
        check("fill_count", 64'(count), 64'd16);
        check("fill_ovf", 64'(overflow), 64'd1);
        check("fill_drops", 64'(drop_count), 64'd2);
        for (int i = 1; i <= 16; i++) begin
            check("drain_value", 64'(rd_data), 64'(i));
            cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        end
        check("drain_empty", 64'(rd_valid), 64'd0);

        // Full with simultaneous push and pop
        for (int i = 1; i <= 16; i++)
            cycle(1'b0, 1'b1, 5'd4, 32'h100 + 32'(i), 1'b0);
        cycle(1'b0, 1'b1, 5'd7, 32'h99, 1'b1);
        check("fullpp_count", 64'(count), 64'd16);
        check("fullpp_drops", 64'(drop_count), 64'd2);
        for (int k = 0; k < 16; k++) begin
            check("fullpp_order", 64'(rd_data), (k < 15) ? 64'(32'h102 + 32'(k)) : 64'h99);
            cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        end
        check("fullpp_empty", 64'(rd_valid), 64'd0);

        // Pointer wrap with streaming reader
        for (int i = 0; i < 40; i++) begin
            cycle(1'b0, 1'b1, 5'd17, 32'h200 + 32'(i), 1'b1);
            check("stream_data", 64'(rd_data), 64'(32'h200 + 32'(i)));
            check("stream_count_le1", 64'(count <= 5'd1), 64'd1);
        end
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        check("stream_empty", 64'(rd_valid), 64'd0);

        // Reset mid-operation: clear, fill with 3 drops, drain to 5 entries
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        for (int i = 1; i <= 19; i++)
            cycle(1'b0, 1'b1, 5'd12, 32'h300 + 32'(i), 1'b0);
        for (int i = 0; i < 11; i++)
            cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        check("pre_rst_count", 64'(count), 64'd5);
        check("pre_rst_drops", 64'(drop_count), 64'd3);
        check("pre_rst_head", 64'(rd_data), 64'h30C);
        // Reset wins over a simultaneous push and pop
        cycle(1'b1, 1'b1, 5'd5, 32'h55, 1'b1);
        check("rst_valid", 64'(rd_valid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_reg", 64'(rd_reg), 64'd0);
        check("rst_data", 64'(rd_data), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_drops", 64'(drop_count), 64'd0);
        cycle(1'b0, 1'b1, 5'd3, 32'h77, 1'b0);
        check("post_rst_count", 64'(count), 64'd1);
        check("post_rst_reg", 64'(rd_reg), 64'd3);
        check("post_rst_data", 64'(rd_data), 64'h77);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        check("post_rst_empty", 64'(rd_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
